memc_ldst_responder: RTL and testbench
======================================

Name: memc_ldst_responder

Overview:
- Memory-access-controller side of the LD/ST interface; the SIMD core's LD/ST unit is the initiator.
- Arbitrates ownership with a request/granted/released handshake.
- Accepts single-beat writes and reads and drives one single-ported SRAM with 1-cycle read latency.
- Returns read data in order through a small return FIFO that honours the initiator's read_pause.

Parameters:
- ADDR_W, 24, width of the memory word address.
- DATA_W, 32, width of a memory data word; equals the exec lane width.
- RD_FIFO_DEPTH, 4, read-return FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  clock.
- reset_poweron_n  in  1  asynchronous, active-low reset.
- ldst__memc__request  in  1  initiator requests ownership.
- memc__ldst__granted  out  1  ownership granted; registered.
- ldst__memc__released  in  1  initiator gives up ownership.
- ldst__memc__write_valid  in  1  write beat valid.
- ldst__memc__write_address  in  ADDR_W  write address.
- ldst__memc__write_data  in  DATA_W  write data.
- memc__ldst__write_ready  out  1  write accepted when valid&&ready.
- ldst__memc__read_valid  in  1  read request valid.
- ldst__memc__read_address  in  ADDR_W  read address.
- memc__ldst__read_ready  out  1  read accepted when valid&&ready.
- memc__ldst__read_data  out  DATA_W  returned read data (FIFO head).
- memc__ldst__read_data_valid  out  1  read_data is valid this cycle.
- ldst__memc__read_pause  in  1  initiator stalls read return.
- other__memc__busy  in  1  competing requester (DMA) owns the SRAM; blocks new grants.
- memc__sram__enable  out  1  SRAM access strobe.
- memc__sram__write  out  1  1 = write, 0 = read.
- memc__sram__address  out  ADDR_W  SRAM address.
- memc__sram__wdata  out  DATA_W  SRAM write data.
- sram__memc__rdata  in  DATA_W  SRAM read data; valid the cycle after a read strobe.
- memc__ldst__proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (asynchronous, reset_poweron_n=0):
  - State=IDLE, granted=0, FIFO empty, in-flight flag=0, proto_err=0.
  - All SRAM strobes 0; read_data_valid=0; read_data=0.
  - Reset mid-transaction discards in-flight reads and FIFO contents; no data is returned afterwards.
- States:
  - IDLE: request && !other__memc__busy -> GRANT.
  - GRANT: granted<=1 -> ACTIVE.
  - ACTIVE: released || !request -> DRAIN.
  - DRAIN: stays until in-flight=0 and FIFO empty; then granted<=0 -> IDLE.
  - Minimum request-to-granted latency is 2 cycles. If other__memc__busy rises in GRANT or ACTIVE, the grant is not revoked.
- write_ready = (state==ACTIVE), combinational from state only.
- read_ready = (state==ACTIVE) && !write_valid && (fifo_count + in_flight < RD_FIFO_DEPTH).
  - Writes take priority on the single SRAM port.
  - A same-cycle write and read: write accepted, read stalled.
  - The credit check ignores a same-cycle pop (conservative).
- SRAM access:
  - Accepted beat drives enable, write, address and wdata combinationally in the acceptance cycle.
  - A read sets in_flight; the next cycle rdata is pushed into the FIFO.
- Return path:
  - read_data_valid = !fifo_empty && !read_pause; read_data = FIFO head.
  - A pop occurs on each cycle with read_data_valid=1.
  - Pause holds the head stable. A push and a pop in the same cycle are legal at any occupancy.
- Read latency (no pause): acceptance cycle N -> read_data_valid at N+2. Return order equals acceptance order.
- FIFO overflow is impossible by construction. If a push finds the FIFO full, proto_err is set and the data is dropped (assertion in simulation).
- proto_err is set and held until reset on:
  - write_valid or read_valid while state is not ACTIVE (the beat is ignored);
  - released asserted while granted=0.
- Address and data pass through unmodified; no wrap or width conversion.

Test Plan:
- Grant: request=1, other_busy=0 at cycle 0 -> granted=1 at cycle 2. Same with other_busy=1 for 5 cycles -> granted stays 0 until 2 cycles after busy falls.
- Write then read: write 0xDEADBEEF to 0x000010, then read 0x000010 -> SRAM write strobe in the acceptance cycle; read_data=0xDEADBEEF with valid exactly 2 cycles after read acceptance.
- Backpressure: 6 back-to-back reads (addr 0..5) with read_pause held 1 -> read_ready drops after 4 acceptances. Release pause -> data 0..5 returned in order with no loss or duplication.
- Write priority: write_valid and read_valid together -> only the write hits the SRAM, read_ready=0. The read is accepted on the following cycle.
- Release with pending reads: released asserted with 2 reads in the FIFO and pause=1 -> granted stays 1. Drop pause -> both returned, then granted falls the next cycle.
- Error and reset: read_valid while in IDLE -> proto_err=1 and no SRAM strobe. Assert reset_poweron_n=0 mid-ACTIVE with 3 FIFO entries -> all outputs 0 immediately, proto_err=0, and no data is returned after reset releases.

Source files
------------

// File: rtl/memc_ldst_responder.sv
// LD/ST-side memory access controller: ownership handshake,
// single-port SRAM drive and in-order read return FIFO.
module memc_ldst_responder #(
  parameter int ADDR_W        = 24,
  parameter int DATA_W        = 32,
  parameter int RD_FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_poweron_n,
  input  logic              ldst__memc__request,
  output logic              memc__ldst__granted,
  input  logic              ldst__memc__released,
  input  logic              ldst__memc__write_valid,
  input  logic [ADDR_W-1:0] ldst__memc__write_address,
  input  logic [DATA_W-1:0] ldst__memc__write_data,
  output logic              memc__ldst__write_ready,
  input  logic              ldst__memc__read_valid,
  input  logic [ADDR_W-1:0] ldst__memc__read_address,
  output logic              memc__ldst__read_ready,
  output logic [DATA_W-1:0] memc__ldst__read_data,
  output logic              memc__ldst__read_data_valid,
  input  logic              ldst__memc__read_pause,
  input  logic              other__memc__busy,
  output logic              memc__sram__enable,
  output logic              memc__sram__write,
  output logic [ADDR_W-1:0] memc__sram__address,
  output logic [DATA_W-1:0] memc__sram__wdata,
  input  logic [DATA_W-1:0] sram__memc__rdata,
  output logic              memc__ldst__proto_err
);
  localparam int PW  = $clog2(RD_FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int CW1 = CW + 1;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    ACTIVE,
    DRAIN
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   granted_nxt;

  logic              in_flight;
  logic [DATA_W-1:0] fifo [RD_FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW1-1:0]    credit;

  logic active;
  logic fifo_empty;
  logic fifo_full;
  logic wr_fire;
  logic rd_fire;
  logic push;
  logic pop;
  logic overflow;
  logic push_ok;
  logic err_set;

  assign active     = (state == ACTIVE);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(RD_FIFO_DEPTH));

  // Credit counts the read in the SRAM pipe; a same-cycle pop is ignored.
  assign credit = {1'b0, count} + CW1'(in_flight);

  assign memc__ldst__write_ready = active;
  assign memc__ldst__read_ready  = active
                                && !ldst__memc__write_valid
                                && (credit < CW1'(RD_FIFO_DEPTH));

  assign wr_fire = ldst__memc__write_valid && active;
  assign rd_fire = ldst__memc__read_valid && memc__ldst__read_ready;

  assign memc__sram__enable  = wr_fire || rd_fire;
  assign memc__sram__write   = wr_fire;
  assign memc__sram__address = wr_fire ? ldst__memc__write_address
                             : rd_fire ? ldst__memc__read_address
                             : '0;
  assign memc__sram__wdata   = wr_fire ? ldst__memc__write_data : '0;

  assign memc__ldst__read_data_valid = !fifo_empty && !ldst__memc__read_pause;
  assign memc__ldst__read_data = fifo_empty ? '0 : fifo[rd_ptr];

  assign push     = in_flight;
  assign pop      = memc__ldst__read_data_valid;
  assign overflow = push && fifo_full && !pop;
  assign push_ok  = push && !overflow;

  assign err_set = ((ldst__memc__write_valid || ldst__memc__read_valid) && !active)
                || (ldst__memc__released && !memc__ldst__granted)
                || overflow;

  always_comb begin
    state_nxt   = state;
    granted_nxt = memc__ldst__granted;
    unique case (state)
      IDLE:
        if (ldst__memc__request && !other__memc__busy) state_nxt = GRANT;
      GRANT: begin
        granted_nxt = 1'b1;
        state_nxt   = ACTIVE;
      end
      ACTIVE:
        if (ldst__memc__released || !ldst__memc__request) state_nxt = DRAIN;
      DRAIN:
        if (!in_flight && fifo_empty) begin
          granted_nxt = 1'b0;
          state_nxt   = IDLE;
        end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      state                 <= IDLE;
      memc__ldst__granted   <= 1'b0;
      memc__ldst__proto_err <= 1'b0;
    end else begin
      state               <= state_nxt;
      memc__ldst__granted <= granted_nxt;
      if (err_set) memc__ldst__proto_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      in_flight <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      in_flight <= rd_fire;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo[wr_ptr] <= sram__memc__rdata;
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!reset_poweron_n) !overflow
  );
endmodule

// File: tb/tb_memc_ldst_responder.sv
// Directed bench for memc_ldst_responder with a small SRAM model.
// Inputs are driven on the falling edge, outputs sampled 1 ns later.
module tb_memc_ldst_responder;
  localparam int AW = 24;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          gnt;
  logic          rel = 1'b0;
  logic          wv = 1'b0;
  logic [AW-1:0] wa = '0;
  logic [DW-1:0] wd = '0;
  logic          wrdy;
  logic          rv = 1'b0;
  logic [AW-1:0] ra = '0;
  logic          rrdy;
  logic [DW-1:0] rd;
  logic          rdv;
  logic          pause = 1'b0;
  logic          busy = 1'b0;
  logic          s_en;
  logic          s_wr;
  logic [AW-1:0] s_a;
  logic [DW-1:0] s_wd;
  logic [DW-1:0] s_rd = '0;
  logic          perr;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] sram [256];
  bit            written [256];

  always #5 clk = ~clk;

  // Unwritten locations read back their own index.
  always @(posedge clk) begin
    if (s_en) begin
      if (s_wr) begin
        sram[s_a[7:0]]    <= s_wd;
        written[s_a[7:0]] <= 1'b1;
      end else begin
        s_rd <= written[s_a[7:0]] ? sram[s_a[7:0]] : DW'(s_a[7:0]);
      end
    end
  end

  memc_ldst_responder #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .RD_FIFO_DEPTH(4)
  ) dut (
    .clk                         (clk),
    .reset_poweron_n             (rst_n),
    .ldst__memc__request         (req),
    .memc__ldst__granted         (gnt),
    .ldst__memc__released        (rel),
    .ldst__memc__write_valid     (wv),
    .ldst__memc__write_address   (wa),
    .ldst__memc__write_data      (wd),
    .memc__ldst__write_ready     (wrdy),
    .ldst__memc__read_valid      (rv),
    .ldst__memc__read_address    (ra),
    .memc__ldst__read_ready      (rrdy),
    .memc__ldst__read_data       (rd),
    .memc__ldst__read_data_valid (rdv),
    .ldst__memc__read_pause      (pause),
    .other__memc__busy           (busy),
    .memc__sram__enable          (s_en),
    .memc__sram__write           (s_wr),
    .memc__sram__address         (s_a),
    .memc__sram__wdata           (s_wd),
    .sram__memc__rdata           (s_rd),
    .memc__ldst__proto_err       (perr)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic acquire();
    step(); req = 1'b1;
    step();
    step(); #1;
    n_cmp++; if (gnt !== 1'b1) begin n_bad++; $display("FAIL acquire granted got %b want 1", gnt); end
  endtask

  task automatic release_own();
    step(); rel = 1'b1; req = 1'b0;
    step(); rel = 1'b0; #1;
    for (int i = 0; i < 8 && gnt !== 1'b0; i++) begin
      step(); #1;
    end
    n_cmp++; if (gnt !== 1'b0) begin n_bad++; $display("FAIL release_done granted got %b want 0", gnt); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); #1;
    n_cmp++; if (gnt !== 1'b0) begin n_bad++; $display("FAIL reset_granted got %b want 0", gnt); end
    n_cmp++; if (rdv !== 1'b0) begin n_bad++; $display("FAIL reset_rdv got %b want 0", rdv); end
    n_cmp++; if (rd !== '0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", rd); end
    n_cmp++; if (perr !== 1'b0) begin n_bad++; $display("FAIL reset_perr got %b want 0", perr); end
    n_cmp++; if (s_en !== 1'b0) begin n_bad++; $display("FAIL reset_sram_en got %b want 0", s_en); end
    n_cmp++; if ({wrdy, rrdy} !== 2'b00) begin n_bad++; $display("FAIL reset_ready got %b want 00", {wrdy, rrdy}); end
    step(); rst_n = 1'b1;
  endtask

  task automatic test_grant();
    step(); req = 1'b1; #1;
    n_cmp++; if (gnt !== 1'b0) begin n_bad++; $display("FAIL grant_c0 got %b want 0", gnt); end
    step(); #1;
    n_cmp++; if (gnt !== 1'b0) begin n_bad++; $display("FAIL grant_c1 got %b want 0", gnt); end
    step(); #1;
    n_cmp++; if (gnt !== 1'b1) begin n_bad++; $display("FAIL grant_c2 got %b want 1", gnt); end
    n_cmp++; if (wrdy !== 1'b1) begin n_bad++; $display("FAIL grant_wrdy got %b want 1", wrdy); end
    release_own();
    step(); busy = 1'b1; req = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) step();
      if (c == 5) busy = 1'b0;
      #1;
      n_cmp++; if (gnt !== 1'b0) begin n_bad++; $display("FAIL grant_busy c%0d got %b want 0", c, gnt); end
    end
    step(); #1;
    n_cmp++; if (gnt !== 1'b1) begin n_bad++; $display("FAIL grant_after_busy got %b want 1", gnt); end
    step(); busy = 1'b1;
    step(); #1;
    n_cmp++; if (gnt !== 1'b1) begin n_bad++; $display("FAIL grant_kept_busy got %b want 1", gnt); end
    busy = 1'b0;
    release_own();
  endtask

  task automatic test_write_read();
    acquire();
    step(); wv = 1'b1; wa = 24'h000010; wd = 32'hDEADBEEF; #1;
    n_cmp++; if ({s_en, s_wr} !== 2'b11) begin n_bad++; $display("FAIL wr_strobe got %b want 11", {s_en, s_wr}); end
    n_cmp++; if (s_a !== 24'h000010) begin n_bad++; $display("FAIL wr_addr got %h want 000010", s_a); end
    n_cmp++; if (s_wd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_data got %h want deadbeef", s_wd); end
    step(); wv = 1'b0; rv = 1'b1; ra = 24'h000010; #1;
    n_cmp++; if ({rrdy, s_en, s_wr} !== 3'b110) begin n_bad++; $display("FAIL rd_accept got %b want 110", {rrdy, s_en, s_wr}); end
    step(); rv = 1'b0; #1;
    n_cmp++; if (rdv !== 1'b0) begin n_bad++; $display("FAIL rd_n1 valid got %b want 0", rdv); end
    step(); #1;
    n_cmp++; if (rdv !== 1'b1) begin n_bad++; $display("FAIL rd_n2 valid got %b want 1", rdv); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_n2 data got %h want deadbeef", rd); end
    step(); #1;
    n_cmp++; if (rdv !== 1'b0) begin n_bad++; $display("FAIL rd_single valid got %b want 0", rdv); end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int got = 0;
    pause = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step(); rv = 1'b1; ra = AW'(acc); #1;
      if (rrdy) acc++;
    end
    n_cmp++; if (acc !== 4) begin n_bad++; $display("FAIL bp_accepted got %0d want 4", acc); end
    n_cmp++; if (rrdy !== 1'b0) begin n_bad++; $display("FAIL bp_ready_low got %b want 0", rrdy); end
    n_cmp++; if (rdv !== 1'b0) begin n_bad++; $display("FAIL bp_paused valid got %b want 0", rdv); end
    for (int c = 0; c < 30 && got < 6; c++) begin
      step(); pause = 1'b0; rv = (acc < 6); ra = AW'(acc); #1;
      if (rdv) begin
        n_cmp++; if (rd !== DW'(got)) begin n_bad++; $display("FAIL bp_order #%0d got %h want %h", got, rd, DW'(got)); end
        got++;
      end
      if (rv && rrdy) acc++;
    end
    rv = 1'b0;
    n_cmp++; if (got !== 6) begin n_bad++; $display("FAIL bp_count got %0d want 6", got); end
    n_cmp++; if (acc !== 6) begin n_bad++; $display("FAIL bp_acc_total got %0d want 6", acc); end
    for (int c = 0; c < 3; c++) begin
      step(); #1;
      n_cmp++; if (rdv !== 1'b0) begin n_bad++; $display("FAIL bp_no_dup c%0d got %b want 0", c, rdv); end
    end
  endtask

  task automatic test_write_priority();
    step(); wv = 1'b1; wa = 24'h000020; wd = 32'h12345678; rv = 1'b1; ra = 24'h000010; #1;
    n_cmp++; if ({wrdy, rrdy} !== 2'b10) begin n_bad++; $display("FAIL prio_ready got %b want 10", {wrdy, rrdy}); end
    n_cmp++; if (s_wr !== 1'b1 || s_a !== 24'h000020) begin n_bad++; $display("FAIL prio_sram got wr=%b a=%h want wr=1 a=000020", s_wr, s_a); end
    step(); wv = 1'b0; #1;
    n_cmp++; if (rrdy !== 1'b1) begin n_bad++; $display("FAIL prio_rd_next got %b want 1", rrdy); end
    n_cmp++; if (s_wr !== 1'b0 || s_a !== 24'h000010) begin n_bad++; $display("FAIL prio_rd_sram got wr=%b a=%h want wr=0 a=000010", s_wr, s_a); end
    step(); rv = 1'b0;
    step(); #1;
    n_cmp++; if (rdv !== 1'b1 || rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL prio_rd_data got v=%b d=%h want v=1 d=deadbeef", rdv, rd); end
    step();
  endtask

  task automatic test_release_pending();
    pause = 1'b1;
    step(); rv = 1'b1; ra = 24'h000002; #1;
    n_cmp++; if (rrdy !== 1'b1) begin n_bad++; $display("FAIL relp_rd0 ready got %b want 1", rrdy); end
    step(); ra = 24'h000003;
    step(); rv = 1'b0; rel = 1'b1; req = 1'b0; #1;
    n_cmp++; if (gnt !== 1'b1) begin n_bad++; $display("FAIL relp_gnt got %b want 1", gnt); end
    step(); rel = 1'b0;
    step();
    step(); #1;
    n_cmp++; if (gnt !== 1'b1 || rdv !== 1'b0) begin n_bad++; $display("FAIL relp_hold got g=%b v=%b want g=1 v=0", gnt, rdv); end
    step(); pause = 1'b0; #1;
    n_cmp++; if (rdv !== 1'b1 || rd !== 32'h2) begin n_bad++; $display("FAIL relp_d0 got v=%b d=%h want v=1 d=2", rdv, rd); end
    step(); #1;
    n_cmp++; if (rdv !== 1'b1 || rd !== 32'h3) begin n_bad++; $display("FAIL relp_d1 got v=%b d=%h want v=1 d=3", rdv, rd); end
    n_cmp++; if (gnt !== 1'b1) begin n_bad++; $display("FAIL relp_gnt_d1 got %b want 1", gnt); end
    step(); #1;
    n_cmp++; if (rdv !== 1'b0) begin n_bad++; $display("FAIL relp_empty got %b want 0", rdv); end
    step(); #1;
    n_cmp++; if (gnt !== 1'b0) begin n_bad++; $display("FAIL relp_drop got %b want 0", gnt); end
  endtask

  task automatic test_error_reset();
    step(); #1;
    n_cmp++; if (perr !== 1'b0) begin n_bad++; $display("FAIL err_clean got %b want 0", perr); end
    step(); rv = 1'b1; ra = 24'h000005; #1;
    n_cmp++; if (s_en !== 1'b0 || rrdy !== 1'b0) begin n_bad++; $display("FAIL err_no_strobe got en=%b rdy=%b want 0 0", s_en, rrdy); end
    step(); rv = 1'b0; #1;
    n_cmp++; if (perr !== 1'b1) begin n_bad++; $display("FAIL err_idle_read got %b want 1", perr); end
    acquire();
    n_cmp++; if (perr !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b want 1", perr); end
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); rv = 1'b1; ra = AW'(i);
    end
    step(); rv = 1'b0;
    step(); #1;
    n_cmp++; if (rdv !== 1'b0) begin n_bad++; $display("FAIL err_fill_paused got %b want 0", rdv); end
    step(); rst_n = 1'b0; pause = 1'b0; req = 1'b0; #1;
    n_cmp++; if (gnt !== 1'b0 || perr !== 1'b0) begin n_bad++; $display("FAIL rst_mid got g=%b e=%b want 0 0", gnt, perr); end
    n_cmp++; if (rdv !== 1'b0 || rd !== '0 || s_en !== 1'b0) begin n_bad++; $display("FAIL rst_mid_out got v=%b d=%h en=%b want 0", rdv, rd, s_en); end
    step(); rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step(); #1;
      n_cmp++; if (rdv !== 1'b0) begin n_bad++; $display("FAIL rst_quiet c%0d got %b want 0", c, rdv); end
    end
    step(); rel = 1'b1;
    step(); rel = 1'b0; #1;
    n_cmp++; if (perr !== 1'b1) begin n_bad++; $display("FAIL err_release got %b want 1", perr); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_grant();
    test_write_read();
    test_backpressure();
    test_write_priority();
    release_own();
    acquire();
    test_release_pending();
    test_error_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
